// File: rtl/seq_detector_param.sv
// Serial sequence detector: a W-bit sliding window is compared to a run-time loadable pattern.
// Optional saturating match counter is built when SEQ_DET_MATCH_COUNT_EN is defined.
module seq_detector_param #(
    parameter int              W       = 4,
    parameter logic [W-1:0]    PATTERN = 4'b1011,
    parameter int              CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         valid,
    input  logic         overlap,
    input  logic         load,
    input  logic [W-1:0] pattern_in,
    output logic         Y,
    output logic [1:0]   state
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int FILL_W = $clog2(W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    logic [W-1:0]      pat_q, pat_d;
    logic [W-1:0]      sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q, y_d;
    logic [W-1:0]      sr_n;
    logic [FILL_W-1:0] fill_n;
    logic              match;
    state_e            state_s;

    always_comb begin
        pat_d  = pat_q;
        sr_d   = sr_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        match  = 1'b0;
        sr_n   = {sr_q[W-2:0], run};
        fill_n = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
        if (load) begin
            pat_d  = pattern_in;
            sr_d   = '0;
            fill_d = '0;
        end else if (valid) begin
            match = (fill_n == FILL_MAX) && (sr_n == pat_q);
            sr_d  = sr_n;
            if (match) begin
                y_d = 1'b1;
                // Non-overlapping mode empties the window; stale sr bits are masked by fill.
                fill_d = overlap ? FILL_MAX : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PATTERN;
            sr_q   <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            sr_q   <= sr_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    always_comb begin
        if (fill_q == '0)
            state_s = ST_IDLE;
        else if (fill_q == FILL_MAX)
            state_s = ST_ARMED;
        else
            state_s = ST_FILL;
    end

    assign state = state_s;
    assign Y     = y_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A clear coinciding with a match leaves that match counted.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = match ? CNT_W'(1) : '0;
        else if (match)
            cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized and directed bench for seq_detector_param against a queue-based reference model.
// Counter checks are included when SEQ_DET_MATCH_COUNT_EN is defined.
module tb_seq_detector_param;

    localparam int           W       = 4;
    localparam logic [W-1:0] PATTERN = 4'b1011;
    localparam int           CNT_W   = 8;
    localparam int           CNT_MAX = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic         valid = 1'b0;
    logic         overlap = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] pattern_in = '0;
    logic         cnt_clr = 1'b0;
    logic         Y;
    logic [1:0]   state;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    seq_detector_param #(.W(W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .valid      (valid),
        .overlap    (overlap),
        .load       (load),
        .pattern_in (pattern_in),
        .Y          (Y),
        .state      (state)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .match_cnt  (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ycount   = 0;

    // Reference model: bits received since the last restart, capped at W.
    bit           hist[$];
    logic [W-1:0] m_pat = PATTERN;
    int           m_y   = 0;
    int           m_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (hist.size() == 0) return 0;
        if (hist.size() < W) return 1;
        return 2;
    endfunction

    function automatic int window_val();
        int v = 0;
        foreach (hist[i]) v = (v << 1) | int'(hist[i]);
        return v;
    endfunction

    task automatic model_update();
        bit m = 1'b0;
        if (reset) begin
            hist.delete();
            m_pat = PATTERN;
            m_y   = 0;
            m_cnt = 0;
            return;
        end
        m_y = 0;
        if (load) begin
            hist.delete();
            m_pat = pattern_in;
        end else if (valid) begin
            hist.push_back(run);
            if (hist.size() > W) void'(hist.pop_front());
            if (hist.size() == W && window_val() == int'(m_pat)) begin
                m   = 1'b1;
                m_y = 1;
                if (!overlap) hist.delete();
            end
        end
        if (cnt_clr) m_cnt = m ? 1 : 0;
        else if (m && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (Y) ycount++;
        chk("y", int'(Y), m_y);
        chk("state", int'(state), exp_state());
`ifdef SEQ_DET_MATCH_COUNT_EN
        chk("cnt", int'(match_cnt), m_cnt);
`endif
    endtask

    task automatic send(input bit b);
        reset = 1'b0; load = 1'b0; valid = 1'b1; run = b;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; valid = 1'b0; cnt_clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        reset = 1'b0; load = 1'b0; valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit s7[7];
        s7 = '{1, 0, 1, 1, 0, 1, 1};

        do_reset();
        do_reset();
        chk("rst_y", int'(Y), 0);
        chk("rst_state", int'(state), 0);

        // Overlapping: pulses after bits 4 and 7
        overlap = 1'b1; ycount = 0;
        foreach (s7[i]) send(s7[i]);
        idle(1);
        chk("ovl_pulses", ycount, 2);
`ifdef SEQ_DET_MATCH_COUNT_EN
        chk("ovl_cnt", int'(match_cnt), 2);
`endif

        // Non-overlapping: single pulse, FILL after bit 7
        do_reset();
        overlap = 1'b0; ycount = 0;
        foreach (s7[i]) send(s7[i]);
        chk("novl_state", int'(state), 1);
        idle(1);
        chk("novl_pulses", ycount, 1);
`ifdef SEQ_DET_MATCH_COUNT_EN
        chk("novl_cnt", int'(match_cnt), 1);
`endif

        // Gaps in valid between bits
        do_reset();
        overlap = 1'b1; ycount = 0;
        send(1); idle(3); send(0); idle(3); send(1); idle(3);
        chk("gap_before", ycount, 0);
        send(1);
        chk("gap_y", int'(Y), 1);
        idle(3);
        chk("gap_pulses", ycount, 1);

        // Load a new pattern mid-window
        do_reset();
        send(1); send(0); send(1);
        pattern_in = 4'b1100; load = 1'b1; valid = 1'b1; run = 1'b1;
        tick();
        load = 1'b0; valid = 1'b0;
        chk("load_state", int'(state), 0);
        ycount = 0;
        send(1); send(0); send(1); send(1); send(0);
        chk("load_nopulse", ycount, 0);
        send(0);
        chk("load_y", int'(Y), 1);

        // Reset mid-stream
        do_reset();
        send(1); send(0); send(1);
        do_reset();
        ycount = 0;
        send(1);
        chk("rst2_state", int'(state), 1);
        chk("rst2_pulses", ycount, 0);
`ifdef SEQ_DET_MATCH_COUNT_EN
        chk("rst2_cnt", int'(match_cnt), 0);

        // Counter saturation and clear-with-match
        pattern_in = 4'b1111; load = 1'b1; tick(); load = 1'b0;
        overlap = 1'b1;
        for (int i = 0; i < CNT_MAX + 20; i++) send(1);
        chk("sat_cnt", int'(match_cnt), CNT_MAX);
        cnt_clr = 1'b1; send(1); cnt_clr = 1'b0;
        chk("clr_match_cnt", int'(match_cnt), 1);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            load    = ($urandom_range(0, 49) == 0);
            valid   = ($urandom_range(0, 9) < 7);
            run     = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) overlap = ~overlap;
            case ($urandom_range(0, 3))
                0: pattern_in = '0;
                1: pattern_in = '1;
                default: pattern_in = W'($urandom);
            endcase
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
